// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the data memory or fabric (slave).
// The master registers all request fields and holds them stable while the request is pending.
interface load_store_unit_if;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusBe;
    logic [31:0] BusWData;
    logic [31:0] BusRData;
    logic        BusReady;

    modport master (
        output BusReq, BusWe, BusAddr, BusBe, BusWData,
        input  BusRData, BusReady
    );

    modport slave (
        input  BusReq, BusWe, BusAddr, BusBe, BusWData,
        output BusRData, BusReady
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: turns a held load/store into one registered req/ready bus transaction,
// steers byte/halfword lanes, extends load data and stalls the core until the access completes.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [2:0]                Funct3,
    input  logic [31:0]               ALUResult,
    input  logic [31:0]               WriteData,
    output logic [31:0]               ReadData,
    output logic                      Stall,
    output logic                      Fault,
    output logic [1:0]                FaultCode,
    load_store_unit_if.master         bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_MIS  = 2'b01;
    localparam logic [1:0] FC_ILL  = 2'b10;
    localparam logic [1:0] FC_TO   = 2'b11;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            req_q, we_q;
    logic [31:0]     addr_q, wdata_q, rdata_q;
    logic [3:0]      be_q;
    logic [1:0]      fcode_q, lsb_q;
    logic [2:0]      f3_q;

    logic            is_mem, illegal, misaligned;
    logic [3:0]      be_n;
    logic [31:0]     wdata_n;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_ext;

    // Request decode from the held instruction fields.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        is_mem     = MemRead | MemWrite;
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_n       = 4'b0000;
        wdata_n    = 32'h0;

        if (MemRead && MemWrite)
            illegal = 1'b1;
        else if (MemWrite)
            illegal = !(Funct3 inside {3'b000, 3'b001, 3'b010});
        else
            illegal = !(Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

        case (Funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << ALUResult[1:0];
                wdata_n = {4{WriteData[7:0]}};
            end
            2'b01: begin
                misaligned = ALUResult[0];
                be_n       = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_n    = {2{WriteData[15:0]}};
            end
            2'b10: begin
                misaligned = (ALUResult[1:0] != 2'b00);
                be_n       = 4'b1111;
                wdata_n    = WriteData;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_mem) state_d = (illegal || misaligned) ? DONE : REQ;
            REQ:     if (bus.BusReady || to_cnt_q == TO_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            fcode_q  <= FC_NONE;
            lsb_q    <= 2'b00;
            f3_q     <= 3'b000;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        f3_q  <= Funct3;
                        lsb_q <= ALUResult[1:0];
                        if (illegal)
                            fcode_q <= FC_ILL;
                        else if (misaligned)
                            fcode_q <= FC_MIS;
                        else begin
                            req_q   <= 1'b1;
                            we_q    <= MemWrite;
                            addr_q  <= {ALUResult[31:2], 2'b00};
                            be_q    <= be_n;
                            wdata_q <= wdata_n;
                        end
                    end
                end
                REQ: begin
                    if (bus.BusReady) begin
                        rdata_q <= bus.BusRData;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= 4'b0000;
                    end else if (to_cnt_q == TO_LAST) begin
                        rdata_q <= 32'h0;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= 4'b0000;
                        fcode_q <= FC_TO;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    to_cnt_q <= '0;
                    fcode_q  <= FC_NONE;
                end
                default: ;
            endcase
        end
    end

    // Lane select and extension of the captured word, using the address/size latched at issue.
    always_comb begin
        case (lsb_q)
            2'b00:   byte_sel = rdata_q[7:0];
            2'b01:   byte_sel = rdata_q[15:8];
            2'b10:   byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = lsb_q[1] ? rdata_q[31:16] : rdata_q[15:0];

        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            3'b010:  load_ext = rdata_q;
            default: load_ext = 32'h0;
        endcase
    end

    assign Stall     = is_mem && (state_q != DONE);
    assign Fault     = (state_q == DONE) && (fcode_q != FC_NONE);
    assign FaultCode = (state_q == DONE) ? fcode_q : FC_NONE;
    assign ReadData  = ((state_q == DONE) && (fcode_q == FC_NONE)) ? load_ext : 32'h0;

    assign bus.BusReq   = req_q;
    assign bus.BusWe    = we_q;
    assign bus.BusAddr  = addr_q;
    assign bus.BusBe    = be_q;
    assign bus.BusWData = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors checked with immediate assertions.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData, ReadData;
    logic        Stall, Fault;
    logic [1:0]  FaultCode;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Fault     (Fault),
        .FaultCode (FaultCode),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drop the instruction and spend one idle cycle.
    task automatic go_idle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        bus_if.BusReady = 1'b0;
        @(negedge clk);
    endtask

    // Present a memory instruction at a negedge; the next posedge is the IDLE evaluation.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
    endtask

    initial begin
        reset = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'h0; WriteData = 32'h0;
        bus_if.BusReady = 1'b0; bus_if.BusRData = 32'h0;

        // Reset state
        #12;
        check("rst_busreq",   32'(bus_if.BusReq),   32'h0);
        check("rst_buswe",    32'(bus_if.BusWe),    32'h0);
        check("rst_busaddr",  bus_if.BusAddr,       32'h0);
        check("rst_busbe",    32'(bus_if.BusBe),    32'h0);
        check("rst_buswdata", bus_if.BusWData,      32'h0);
        check("rst_readdata", ReadData,             32'h0);
        check("rst_fault",    32'(Fault),           32'h0);
        check("rst_stall",    32'(Stall),           32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // LW 0x100, zero wait states
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        bus_if.BusReady = 1'b1; bus_if.BusRData = 32'hDEAD_BEEF;
        #1 check("lw_stall_c0", 32'(Stall), 32'h1);
        @(negedge clk);
        check("lw_req",   32'(bus_if.BusReq), 32'h1);
        check("lw_we",    32'(bus_if.BusWe),  32'h0);
        check("lw_be",    32'(bus_if.BusBe),  32'hF);
        check("lw_addr",  bus_if.BusAddr,     32'h0000_0100);
        check("lw_stall_c1", 32'(Stall), 32'h1);
        @(negedge clk);
        check("lw_stall_done", 32'(Stall),    32'h0);
        check("lw_rdata",  ReadData,          32'hDEAD_BEEF);
        check("lw_fault",  32'(Fault),        32'h0);
        check("lw_req_off", 32'(bus_if.BusReq), 32'h0);
        go_idle();

        // LB 0x103 -> sign-extended top byte
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        bus_if.BusReady = 1'b1; bus_if.BusRData = 32'h80FF_0000;
        @(negedge clk);
        check("lb_addr", bus_if.BusAddr,     32'h0000_0100);
        check("lb_be",   32'(bus_if.BusBe),  32'h8);
        @(negedge clk);
        check("lb_rdata", ReadData, 32'hFFFF_FF80);
        go_idle();

        // LBU 0x103 -> zero-extended
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        bus_if.BusReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lbu_rdata", ReadData, 32'h0000_0080);
        go_idle();

        // LH 0x102 -> upper half sign-extended
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        bus_if.BusReady = 1'b1;
        @(negedge clk);
        check("lh_be", 32'(bus_if.BusBe), 32'hC);
        @(negedge clk);
        check("lh_rdata", ReadData, 32'hFFFF_80FF);
        go_idle();

        // SH 0x202 with two wait states
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
        bus_if.BusReady = 1'b0;
        @(negedge clk);
        check("sh_req_c1", 32'(bus_if.BusReq), 32'h1);
        check("sh_we",     32'(bus_if.BusWe),  32'h1);
        check("sh_be",     32'(bus_if.BusBe),  32'hC);
        check("sh_wdata",  bus_if.BusWData,    32'hABCD_ABCD);
        check("sh_addr",   bus_if.BusAddr,     32'h0000_0200);
        @(negedge clk);
        check("sh_req_c2", 32'(bus_if.BusReq), 32'h1);
        check("sh_stall_c2", 32'(Stall), 32'h1);
        @(negedge clk);
        check("sh_req_c3", 32'(bus_if.BusReq), 32'h1);
        check("sh_stall_c3", 32'(Stall), 32'h1);
        bus_if.BusReady = 1'b1;
        @(negedge clk);
        check("sh_stall_done", 32'(Stall),        32'h0);
        check("sh_req_off",    32'(bus_if.BusReq), 32'h0);
        check("sh_fault",      32'(Fault),         32'h0);
        go_idle();

        // SB to byte lane 1: replicated data, single enable
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A);
        bus_if.BusReady = 1'b1;
        @(negedge clk);
        check("sb_be",    32'(bus_if.BusBe), 32'h2);
        check("sb_wdata", bus_if.BusWData,   32'h5A5A_5A5A);
        @(negedge clk);
        go_idle();

        // Misaligned LW 0x101: no bus access, fault in second cycle
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        bus_if.BusReady = 1'b1; bus_if.BusRData = 32'hFFFF_FFFF;
        #1 check("mis_stall_c0", 32'(Stall), 32'h1);
        @(negedge clk);
        check("mis_req",    32'(bus_if.BusReq), 32'h0);
        check("mis_fault",  32'(Fault),     32'h1);
        check("mis_code",   32'(FaultCode), 32'h1);
        check("mis_rdata",  ReadData,       32'h0);
        check("mis_stall",  32'(Stall),     32'h0);
        go_idle();
        check("mis_fault_pulse", 32'(Fault), 32'h0);

        // Illegal: load Funct3=011
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        @(negedge clk);
        check("ill_ld_code", 32'(FaultCode), 32'h2);
        check("ill_ld_req",  32'(bus_if.BusReq), 32'h0);
        go_idle();

        // Illegal: store Funct3=100
        issue(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0);
        @(negedge clk);
        check("ill_st_code", 32'(FaultCode), 32'h2);
        go_idle();

        // Illegal: MemRead and MemWrite together
        issue(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0);
        @(negedge clk);
        check("ill_rw_code", 32'(FaultCode), 32'h2);
        check("ill_rw_fault", 32'(Fault), 32'h1);
        go_idle();

        // Timeout: BusReady never rises
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        bus_if.BusReady = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check($sformatf("to_req_c%0d", i), 32'(bus_if.BusReq), 32'h1);
        end
        @(negedge clk);
        check("to_req_off", 32'(bus_if.BusReq), 32'h0);
        check("to_fault",   32'(Fault),     32'h1);
        check("to_code",    32'(FaultCode), 32'h3);
        check("to_rdata",   ReadData,       32'h0);
        check("to_stall",   32'(Stall),     32'h0);
        go_idle();

        // Reset mid-REQ, then the held LW reissues
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        bus_if.BusReady = 1'b0;
        @(negedge clk);
        check("rr_req_pre", 32'(bus_if.BusReq), 32'h1);
        reset = 1'b0;
        #1 check("rr_req_async", 32'(bus_if.BusReq), 32'h0);
        check("rr_stall_held", 32'(Stall), 32'h1);
        @(negedge clk);
        check("rr_req_inrst", 32'(bus_if.BusReq), 32'h0);
        reset = 1'b1;
        bus_if.BusReady = 1'b1; bus_if.BusRData = 32'h1122_3344;
        @(negedge clk);
        check("rr_req_again", 32'(bus_if.BusReq), 32'h1);
        check("rr_addr",      bus_if.BusAddr,     32'h0000_0400);
        @(negedge clk);
        check("rr_rdata", ReadData,   32'h1122_3344);
        check("rr_stall", 32'(Stall), 32'h0);
        check("rr_fault", 32'(Fault), 32'h0);
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the core datapath. It consumes the datapath's ALUResult (effective address) and WriteData (store data), and returns the ReadData word that the datapath's result mux writes back.
- It turns single-cycle load/store intent into a registered req/ready bus transaction, with byte/halfword lane steering and sign/zero extension.
- It drives Stall, which the core uses to deassert the datapath's PCEn and RegWrite until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16: maximum REQ cycles waiting for BusReady before the access is aborted with a fault.
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  current instruction is a load (level, held while Stall=1).
- MemWrite  in  1  current instruction is a store (level, held while Stall=1).
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  in  32  effective byte address.
- WriteData  in  32  store data (rs2).
- ReadData  out  32  extended load result; valid only in DONE.
- Stall  out  1  high while the memory instruction must be held.
- Fault  out  1  one-cycle pulse in DONE when the access faulted.
- FaultCode  out  2  01 misaligned, 10 illegal Funct3, 11 bus timeout, 00 none.
- BusReq  out  1  registered request.
- BusWe  out  1  registered write enable.
- BusAddr  out  32  registered word address; bits[1:0] are forced to 00.
- BusBe  out  4  registered byte enables.
- BusWData  out  32  registered lane-replicated store data.
- BusRData  in  32  read data, sampled when BusReq and BusReady are both high.
- BusReady  in  1  slave completion strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - BusReq=0, BusWe=0, BusAddr=0, BusBe=0, BusWData=0.
  - Captured load data, ReadData, Fault and FaultCode all cleared to 0.
  - If reset asserts mid-transaction, BusReq drops immediately. The instruction restarts from IDLE after reset release.
- States: IDLE, REQ, DONE.
- Stall = (MemRead | MemWrite) & (state != DONE). Stall is combinational, so it is high in the first cycle of the instruction.
- If MemRead and MemWrite are both high, the access is treated as illegal (FaultCode 10).
- IDLE:
  - No memory operation: stay in IDLE.
  - Memory operation that is misaligned or uses an illegal Funct3: go to DONE with the fault latched; no bus access is made.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal means any Funct3 outside {000, 001, 010, 100, 101} for a load, or outside {000, 001, 010} for a store.
  - Otherwise go to REQ and register the bus outputs. BusReq=1, BusWe=MemWrite, BusAddr={addr[31:2],2'b00}, and BusBe/BusWData are loaded.
- Byte enables and store data:
  - B: BusBe=0001 shifted left by addr[1:0]; BusWData={4{wd[7:0]}}.
  - H: BusBe=0011 shifted left by addr[1]*2; BusWData={2{wd[15:0]}}.
  - W: BusBe=1111; BusWData=wd.
- REQ:
  - Bus outputs are held stable.
  - The timeout counter increments on each cycle with BusReady=0.
  - BusReady=1: capture BusRData, clear BusReq/BusWe/BusBe, go to DONE.
  - Counter reaching TIMEOUT_CYCLES-1 while BusReady=0: abort. Clear BusReq, latch FaultCode 11, set captured data to 0, go to DONE.
- DONE:
  - Stall=0, so the core commits RegWrite and advances PC on this edge.
  - Fault is high if a fault was latched.
  - Next state is always IDLE; the counter clears.
- ReadData in DONE:
  - Select the byte or half at addr[1:0] from the captured data.
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - ReadData is 0 outside DONE and on any fault.
- Latency: a zero-wait-state bus gives the instruction 3 cycles (IDLE, REQ, DONE). Each wait state adds 1 cycle. Faults without a bus access take 2 cycles.
- Back-to-back memory instructions: DONE→IDLE, then the new request is evaluated in IDLE. BusReq is therefore never asserted in two consecutive transactions without an intervening idle cycle.
- BusRData is ignored outside REQ. BusReady outside REQ has no effect.

Test Plan:
- LW from addr 0x100, BusReady on the first REQ cycle, BusRData=0xDEADBEEF -> Stall high for 2 cycles, BusBe=1111, ReadData=0xDEADBEEF in DONE, Fault=0.
- LB from addr 0x103, BusRData=0x80FF0000 -> BusAddr=0x100, ReadData=0xFFFFFF80. LBU at the same address -> ReadData=0x00000080.
- SH with addr 0x202, WriteData=0x1234ABCD, 2 wait states -> BusWe=1, BusBe=1100, BusWData=0xABCDABCD, BusReq held 3 cycles, Stall low after 4 cycles.
- LW from addr 0x101 -> no BusReq, Fault pulse with FaultCode=01 in the second cycle, ReadData=0.
- LW with BusReady held 0 -> BusReq drops after TIMEOUT_CYCLES cycles, Fault pulse with FaultCode=11, ReadData=0, Stall released.
- reset pulsed low mid-REQ -> BusReq=0 immediately, state IDLE. After release, the held LW reissues and completes normally.
